axi_ram_slave: RTL and testbench

AXI4 slave memory that sits directly downstream of the IOb-to-AXI bridge and serves its INCR read and write bursts from an internal two-port word memory. It provides independent write (AW/W/B) and read (AR/R) channel state machines, with one outstanding burst per channel. Its uses are simulation and on-chip scratch memory behind the bridge.

---
 rtl/axi_ram_slave.sv | 181 ++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 slave word memory serving INCR bursts behind the
// IOb-to-AXI bridge. The write (AW/W/B) and read (AR/R) channels each run
// their own FSM and accept one outstanding burst at a time.
//
// Handshake semantics: a beat transfers on a rising clk_i edge where both
// valid and ready are high. Once raised, the slave's valid outputs and their
// payload (bid, rid, rdata, rlast) stay stable until the matching ready is
// seen. Ready outputs are pure functions of the FSM state.
module axi_ram_slave #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STRB_WIDTH   = DATA_WIDTH / 8,
   parameter int AXI_ID_WIDTH = 8,
   parameter int MEM_ADDR_W   = 10
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [AXI_ID_WIDTH-1:0] axi_awid_i,
   input  logic [ADDR_WIDTH-1:0]   axi_awaddr_i,
   input  logic [7:0]              axi_awlen_i,
   input  logic                    axi_awvalid_i,
   output logic                    axi_awready_o,
   input  logic [DATA_WIDTH-1:0]   axi_wdata_i,
   input  logic [STRB_WIDTH-1:0]   axi_wstrb_i,
   input  logic                    axi_wvalid_i,
   output logic                    axi_wready_o,
   output logic [AXI_ID_WIDTH-1:0] axi_bid_o,
   output logic [1:0]              axi_bresp_o,
   output logic                    axi_bvalid_o,
   input  logic                    axi_bready_i,
   input  logic [AXI_ID_WIDTH-1:0] axi_arid_i,
   input  logic [ADDR_WIDTH-1:0]   axi_araddr_i,
   input  logic [7:0]              axi_arlen_i,
   input  logic                    axi_arvalid_i,
   output logic                    axi_arready_o,
   output logic [AXI_ID_WIDTH-1:0] axi_rid_o,
   output logic [DATA_WIDTH-1:0]   axi_rdata_o,
   output logic [1:0]              axi_rresp_o,
   output logic                    axi_rlast_o,
   output logic                    axi_rvalid_o,
   input  logic                    axi_rready_i
);

   localparam int DEPTH = 1 << MEM_ADDR_W;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

   w_state_t w_state;
   r_state_t r_state;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [MEM_ADDR_W-1:0] widx;
   logic [MEM_ADDR_W-1:0] ridx;
   logic [7:0]            wcnt;
   logic [7:0]            rcnt;

   // Byte offset and address bits above the memory window are don't-care.
   logic unused_addr;
   assign unused_addr = ^{axi_awaddr_i[ADDR_WIDTH-1:MEM_ADDR_W+2], axi_awaddr_i[1:0],
                          axi_araddr_i[ADDR_WIDTH-1:MEM_ADDR_W+2], axi_araddr_i[1:0]};

   assign axi_bresp_o = 2'b00;
   assign axi_rresp_o = 2'b00;

   // Byte-masked memory write on every accepted W beat; held off during reset
   always_ff @(posedge clk_i) begin
      if (rst_n_i && w_state == W_DATA && axi_wvalid_i) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (axi_wstrb_i[b]) mem[widx][8*b +: 8] <= axi_wdata_i[8*b +: 8];
         end
      end
   end

   // Write channel FSM: AW accept, count W beats, return B
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         w_state       <= W_IDLE;
         widx          <= '0;
         wcnt          <= '0;
         axi_awready_o <= 1'b1;
         axi_wready_o  <= 1'b0;
         axi_bvalid_o  <= 1'b0;
         axi_bid_o     <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (axi_awvalid_i) begin
                  axi_bid_o     <= axi_awid_i;
                  widx          <= axi_awaddr_i[MEM_ADDR_W+1:2];
                  wcnt          <= axi_awlen_i;
                  axi_awready_o <= 1'b0;
                  axi_wready_o  <= 1'b1;
                  w_state       <= W_DATA;
               end
            end
            W_DATA: begin
               if (axi_wvalid_i) begin
                  widx <= widx + 1'b1;
                  // Burst length comes from awlen alone; wlast is not present.
                  if (wcnt == 8'd0) begin
                     axi_wready_o <= 1'b0;
                     axi_bvalid_o <= 1'b1;
                     w_state      <= W_RESP;
                  end else begin
                     wcnt <= wcnt - 8'd1;
                  end
               end
            end
            W_RESP: begin
               if (axi_bready_i) begin
                  axi_bvalid_o  <= 1'b0;
                  axi_awready_o <= 1'b1;
                  w_state       <= W_IDLE;
               end
            end
            default: begin
               w_state       <= W_IDLE;
               axi_awready_o <= 1'b1;
               axi_wready_o  <= 1'b0;
               axi_bvalid_o  <= 1'b0;
            end
         endcase
      end
   end

   // Read channel FSM: AR accept, then fetch/present each beat in turn
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state       <= R_IDLE;
         ridx          <= '0;
         rcnt          <= '0;
         axi_arready_o <= 1'b1;
         axi_rvalid_o  <= 1'b0;
         axi_rlast_o   <= 1'b0;
         axi_rid_o     <= '0;
         axi_rdata_o   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (axi_arvalid_i) begin
                  axi_rid_o     <= axi_arid_i;
                  ridx          <= axi_araddr_i[MEM_ADDR_W+1:2];
                  rcnt          <= axi_arlen_i;
                  axi_arready_o <= 1'b0;
                  r_state       <= R_FETCH;
               end
            end
            R_FETCH: begin
               // Synchronous read; a same-cycle write to this word is not seen.
               axi_rdata_o  <= mem[ridx];
               axi_rvalid_o <= 1'b1;
               axi_rlast_o  <= (rcnt == 8'd0);
               r_state      <= R_DATA;
            end
            R_DATA: begin
               if (axi_rready_i) begin
                  axi_rvalid_o <= 1'b0;
                  axi_rlast_o  <= 1'b0;
                  if (rcnt == 8'd0) begin
                     axi_arready_o <= 1'b1;
                     r_state       <= R_IDLE;
                  end else begin
                     rcnt    <= rcnt - 8'd1;
                     ridx    <= ridx + 1'b1;
                     r_state <= R_FETCH;
                  end
               end
            end
            default: begin
               r_state       <= R_IDLE;
               axi_arready_o <= 1'b1;
               axi_rvalid_o  <= 1'b0;
               axi_rlast_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed testbench for axi_ram_slave (memory window of 16 words so that
// address wrap is reachable). Inputs change on the falling edge and outputs
// are observed there too, so a handshake seen at a falling edge completes at
// the following rising edge.
module tb_axi_ram_slave;

   logic        clk;
   logic        rst_n;
   logic [7:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [7:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [7:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic        arvalid;
   logic        arready;
   logic [7:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_q[$];

   axi_ram_slave #(.MEM_ADDR_W(4)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen),
      .axi_awvalid_i(awvalid), .axi_awready_o(awready),
      .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wvalid_i(wvalid),
      .axi_wready_o(wready),
      .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid),
      .axi_bready_i(bready),
      .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen),
      .axi_arvalid_i(arvalid), .axi_arready_o(arready),
      .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp),
      .axi_rlast_o(rlast), .axi_rvalid_o(rvalid), .axi_rready_i(rready)
   );

   // clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // ---------------- driver tasks (entered and left on a falling edge) -----

   task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
      int t = 0;
      awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
      while (!awready && t < 100) begin @(negedge clk); t++; end
      check("aw_ready", {31'd0, awready}, 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input int gap);
      int t = 0;
      wvalid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         check("w_gap_ready", {31'd0, wready}, 32'd1);
      end
      wdata = data; wstrb = strb; wvalid = 1'b1;
      while (!wready && t < 100) begin @(negedge clk); t++; end
      check("w_ready", {31'd0, wready}, 32'd1);
      @(negedge clk);
      wvalid = 1'b0;
   endtask

   task automatic b_wait(input logic [7:0] id, input int hold);
      int t = 0;
      while (!bvalid && t < 100) begin @(negedge clk); t++; end
      check("b_valid", {31'd0, bvalid}, 32'd1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("b_hold_valid", {31'd0, bvalid}, 32'd1);
         check("b_hold_id", {24'd0, bid}, {24'd0, id});
      end
      check("b_id", {24'd0, bid}, {24'd0, id});
      check("b_resp", {30'd0, bresp}, 32'd0);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("b_done_valid", {31'd0, bvalid}, 32'd0);
      check("b_done_awready", {31'd0, awready}, 32'd1);
   endtask

   task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
      int t = 0;
      arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
      while (!arready && t < 100) begin @(negedge clk); t++; end
      check("ar_ready", {31'd0, arready}, 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
   endtask

   // Receives n beats, popping expected data from the scoreboard. Beat
   // hold_beat is left un-acknowledged for hold cycles.
   task automatic r_recv(input logic [7:0] id, input int n, input int hold_beat, input int hold);
      logic [31:0] exp_d;
      for (int i = 0; i < n; i++) begin
         int gap = 0;
         while (!rvalid && gap < 100) begin @(negedge clk); gap++; end
         check("r_valid", {31'd0, rvalid}, 32'd1);
         check("r_cadence", gap, 32'd1);
         exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
         if (i == hold_beat) begin
            for (int h = 0; h < hold; h++) begin
               @(negedge clk);
               check("r_hold_valid", {31'd0, rvalid}, 32'd1);
               check("r_hold_data", rdata, exp_d);
               check("r_hold_last", {31'd0, rlast}, {31'd0, i == n - 1});
            end
         end
         check("r_data", rdata, exp_d);
         check("r_last", {31'd0, rlast}, {31'd0, i == n - 1});
         check("r_id", {24'd0, rid}, {24'd0, id});
         check("r_resp", {30'd0, rresp}, 32'd0);
         rready = 1'b1;
         @(negedge clk);
         rready = 1'b0;
      end
      check("r_done_arready", {31'd0, arready}, 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_awready", {31'd0, awready}, 32'd1);
      check("rst_arready", {31'd0, arready}, 32'd1);
      check("rst_wready", {31'd0, wready}, 32'd0);
      check("rst_bvalid", {31'd0, bvalid}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_rlast", {31'd0, rlast}, 32'd0);
      check("rst_bid", {24'd0, bid}, 32'd0);
      check("rst_rid", {24'd0, rid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // single write then read at 0x10 (word 4)
      aw_send(8'h3C, 32'h10, 8'd0);
      check("aw_then_wready", {31'd0, wready}, 32'd1);
      w_beat(32'hDEAD_BEEF, 4'hF, 0);
      check("b_latency", {31'd0, bvalid}, 32'd1);
      b_wait(8'h3C, 0);
      ar_send(8'hA5, 32'h10, 8'd0);
      exp_q.push_back(32'hDEAD_BEEF);
      r_recv(8'hA5, 1, -1, 0);

      // 8-beat burst at 0x100 (word 0 of the 16-word window)
      aw_send(8'h11, 32'h100, 8'd7);
      for (int i = 0; i < 8; i++) w_beat(i, 4'hF, 0);
      check("burst_b_latency", {31'd0, bvalid}, 32'd1);
      b_wait(8'h11, 0);
      ar_send(8'h22, 32'h100, 8'd7);
      for (int i = 0; i < 8; i++) exp_q.push_back(i);
      r_recv(8'h22, 8, -1, 0);

      // strobes on word 9
      aw_send(8'h01, 32'h24, 8'd0);
      w_beat(32'hFFFF_FFFF, 4'hF, 0);
      b_wait(8'h01, 0);
      aw_send(8'h02, 32'h24, 8'd0);
      w_beat(32'h0000_0000, 4'h5, 0);
      b_wait(8'h02, 0);
      ar_send(8'h03, 32'h24, 8'd0);
      exp_q.push_back(32'hFF00_FF00);
      r_recv(8'h03, 1, -1, 0);

      // wrap: 4 beats from word 14 land in 14, 15, 0, 1; word 2 untouched
      aw_send(8'h40, 32'h38, 8'd3);
      w_beat(32'h1111_0014, 4'hF, 0);
      w_beat(32'h1111_0015, 4'hF, 0);
      w_beat(32'h1111_0000, 4'hF, 0);
      w_beat(32'h1111_0001, 4'hF, 0);
      b_wait(8'h40, 0);
      ar_send(8'h41, 32'h38, 8'd4);
      exp_q.push_back(32'h1111_0014);
      exp_q.push_back(32'h1111_0015);
      exp_q.push_back(32'h1111_0000);
      exp_q.push_back(32'h1111_0001);
      exp_q.push_back(32'h0000_0002);
      r_recv(8'h41, 5, -1, 0);

      // backpressure: W gaps, B and R held off for 5 cycles
      aw_send(8'h50, 32'h28, 8'd2);
      w_beat(32'hA000_000A, 4'hF, 2);
      w_beat(32'hA000_000B, 4'hF, 3);
      w_beat(32'hA000_000C, 4'hF, 1);
      b_wait(8'h50, 5);
      ar_send(8'h51, 32'h28, 8'd2);
      exp_q.push_back(32'hA000_000A);
      exp_q.push_back(32'hA000_000B);
      exp_q.push_back(32'hA000_000C);
      r_recv(8'h51, 3, 2, 5);
      ar_send(8'h52, 32'h2C, 8'd1);
      exp_q.push_back(32'hA000_000B);
      exp_q.push_back(32'hA000_000C);
      r_recv(8'h52, 2, 0, 5);

      // concurrency: read words 0..2 while writing words 12..13
      exp_q.push_back(32'h1111_0000);
      exp_q.push_back(32'h1111_0001);
      exp_q.push_back(32'h0000_0002);
      fork
         begin
            ar_send(8'h60, 32'h00, 8'd2);
            r_recv(8'h60, 3, -1, 0);
         end
         begin
            aw_send(8'h61, 32'h30, 8'd1);
            w_beat(32'hC0DE_000C, 4'hF, 0);
            w_beat(32'hC0DE_000D, 4'hF, 1);
            b_wait(8'h61, 2);
         end
      join
      ar_send(8'h62, 32'h30, 8'd1);
      exp_q.push_back(32'hC0DE_000C);
      exp_q.push_back(32'hC0DE_000D);
      r_recv(8'h62, 2, -1, 0);

      // reset in the middle of a 4-beat write at word 5
      aw_send(8'h70, 32'h14, 8'd3);
      w_beat(32'h5555_5555, 4'hF, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_awready", {31'd0, awready}, 32'd1);
      check("midrst_bvalid", {31'd0, bvalid}, 32'd0);
      check("midrst_wready", {31'd0, wready}, 32'd0);
      @(negedge clk);
      check("post_rst_bvalid", {31'd0, bvalid}, 32'd0);
      aw_send(8'h71, 32'h18, 8'd0);
      w_beat(32'h6666_6666, 4'hF, 0);
      b_wait(8'h71, 0);
      ar_send(8'h72, 32'h14, 8'd2);
      exp_q.push_back(32'h5555_5555);
      exp_q.push_back(32'h6666_6666);
      exp_q.push_back(32'h0000_0007);
      r_recv(8'h72, 3, -1, 0);

      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
